bisection_ctrl: RTL and testbench

// Closed-loop bisection controller that finds the reference current i_ref
// at which the externally measured quantity measured_q reaches desired_q.
// It sits between the control supervisor (desired_q, i_ref_setup, ready)
// and the plant/ADC path (i_ref out, measured_q in).
// The plant is taken to be monotonic non-decreasing: more i_ref gives more q.
//

---
 rtl/bisection_ctrl.sv | 129 ++++++++++++
 tb/tb_bisection_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bisection_ctrl.sv
// bisection_ctrl
//   Closed-loop bisection search for the reference current i_ref at which the
//   plant's measured_q reaches desired_q. The plant must be monotonic
//   non-decreasing in i_ref.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   ready        in   run enable; 0 freezes all state
//   desired_q    in   target q (latched at search start)
//   measured_q   in   plant q for the i_ref driven in the previous cycle
//   i_ref_setup  in   upper bound of the search interval (sampled at start)
//   i_ref        out  registered reference to the plant
//   converged    out  high in DONE when |measured_q - desired_q| <= TOL
//   done         out  high in DONE (converged or interval exhausted)
module bisection_ctrl #(
    parameter int WIDTH = 10,
    parameter int TOL   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ready,
    input  logic [WIDTH-1:0] desired_q,
    input  logic [WIDTH-1:0] measured_q,
    input  logic [WIDTH-1:0] i_ref_setup,
    output logic [WIDTH-1:0] i_ref,
    output logic             converged,
    output logic             done
);

    typedef enum logic [2:0] {IDLE, CALC, SETTLE, EVAL, DONE} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] a, a_d, b, b_d, c, c_d, error, error_d, q_tgt, q_tgt_d;
    logic [WIDTH-1:0] i_ref_d;
    logic             converged_d, done_d;

    // Midpoint in WIDTH+1 bits so a+b cannot wrap.
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] mid, diff, a_upd, b_upd;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign mid  = WIDTH'(sum >> 1);
    assign diff = (measured_q >= q_tgt) ? (measured_q - q_tgt) : (q_tgt - measured_q);

    // Narrowed interval after this EVAL; c always lies in [a, b] so b_upd >= a_upd.
    assign a_upd = (measured_q < q_tgt) ? c : a;
    assign b_upd = (measured_q < q_tgt) ? b : c;

    always_comb begin
        state_d     = state;
        a_d         = a;
        b_d         = b;
        c_d         = c;
        error_d     = error;
        q_tgt_d     = q_tgt;
        i_ref_d     = i_ref;
        converged_d = converged;
        done_d      = done;
        if (ready) begin
            case (state)
                IDLE: begin
                    a_d     = '0;
                    b_d     = i_ref_setup;
                    q_tgt_d = desired_q;
                    state_d = CALC;
                end
                CALC: begin
                    c_d     = mid;
                    i_ref_d = mid;
                    state_d = SETTLE;
                end
                SETTLE: state_d = EVAL;
                EVAL: begin
                    error_d = diff;
                    if (diff <= WIDTH'(TOL)) begin
                        converged_d = 1'b1;
                        done_d      = 1'b1;
                        state_d     = DONE;
                    end else begin
                        a_d = a_upd;
                        b_d = b_upd;
                        if ((b_upd - a_upd) <= WIDTH'(1)) begin
                            converged_d = 1'b0;
                            done_d      = 1'b1;
                            state_d     = DONE;
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
                DONE: begin
                    // A new target restarts the search; i_ref keeps the last c until then.
                    if (desired_q != q_tgt) begin
                        converged_d = 1'b0;
                        done_d      = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            a         <= '0;
            b         <= '0;
            c         <= '0;
            error     <= '1;
            q_tgt     <= '0;
            i_ref     <= '0;
            converged <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            a         <= a_d;
            b         <= b_d;
            c         <= c_d;
            error     <= error_d;
            q_tgt     <= q_tgt_d;
            i_ref     <= i_ref_d;
            converged <= converged_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_bisection_ctrl.sv
module tb_bisection_ctrl;
    localparam int W   = 10;
    localparam int TOL = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] desired_q = '0;
    logic [W-1:0] measured_q = '0;
    logic [W-1:0] i_ref_setup = '0;
    logic [W-1:0] i_ref;
    logic         converged, done;

    int total = 0;
    int bad   = 0;
    int gain  = 1;   // plant: q = (i_ref * gain) >> 3, monotonic for gain 1..8

    always #5 clk = ~clk;

    always @(posedge clk) measured_q <= W'((int'(i_ref) * gain) >> 3);

    bisection_ctrl #(.WIDTH(W), .TOL(TOL)) dut (
        .clk(clk), .rst(rst), .ready(ready), .desired_q(desired_q),
        .measured_q(measured_q), .i_ref_setup(i_ref_setup),
        .i_ref(i_ref), .converged(converged), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int plant(input int i);
        return ((i * gain) >> 3) & ((1 << W) - 1);
    endfunction

    // Plain bisection over [0, setup] on the plant function.
    task automatic model(input int d, input int setup, output int fin, output int conv, output int iters);
        int lo, hi, mid, q, err;
        lo = 0; hi = setup; iters = 0; conv = 0; fin = 0;
        forever begin
            iters++;
            mid = (lo + hi) / 2;
            fin = mid;
            q   = plant(mid);
            err = (q > d) ? q - d : d - q;
            if (err <= TOL) begin conv = 1; break; end
            if (q < d) lo = mid; else hi = mid;
            if (hi - lo <= 1) begin conv = 0; break; end
        end
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        ready = 1'b0;
        rst   = 1'b0;
        #2 rst = 1'b1;
        step;
    endtask

    // restart=1: the search starts from DONE (one extra cycle through IDLE).
    task automatic run(input string tag, input int d, input int setup, input int pause_at, input bit restart);
        int fin, conv, it, cyc, exp_cyc;
        logic [W-1:0] held;
        model(d, setup, fin, conv, it);
        desired_q = W'(d); i_ref_setup = W'(setup); ready = 1'b1; cyc = 0;
        do begin
            step; cyc++;
            if (pause_at != 0 && cyc == pause_at) begin
                held  = i_ref;
                ready = 1'b0;
                repeat (5) begin step; cyc++; end
                chk({tag, "_frz_iref"}, 32'(i_ref), 32'(held));
                chk({tag, "_frz_done"}, 32'(done), 0);
                ready = 1'b1;
            end
            // Mid-search bound change must be ignored.
            if (cyc == 4) i_ref_setup = W'($urandom_range(0, (1 << W) - 1));
        end while (!done && cyc < 400);
        exp_cyc = (restart ? 2 : 1) + 3 * it + (pause_at != 0 ? 5 : 0);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_conv"}, 32'(converged), 32'(conv));
        chk({tag, "_iref"}, 32'(i_ref), 32'(fin));
        chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    endtask

    initial begin
        int d, s, q;
        #12;
        chk("rst_iref", 32'(i_ref), 0);
        chk("rst_conv", 32'(converged), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b1;
        step;

        gain = 1;
        run("c1", 110, 1023, 0, 0);
        chk("c1_iref_const", 32'(i_ref), 895);
        chk("c1_q", 32'(measured_q), 111);

        run("c5", 50, 1023, 0, 1);
        q = int'(measured_q);
        chk("c5_tol", 32'((q >= 49 && q <= 51) ? 1 : 0), 1);

        run("c2", 0, 1023, 0, 1);
        chk("c2_q", 32'((measured_q <= 1) ? 1 : 0), 1);

        run("c3", 200, 1023, 0, 1);
        chk("c3_iref_const", 32'(i_ref), 1022);
        chk("c3_conv_const", 32'(converged), 0);

        do_reset;
        run("c4", 110, 1023, 5, 0);
        chk("c4_iref_const", 32'(i_ref), 895);

        // Asynchronous reset during SETTLE.
        do_reset;
        desired_q = 110; i_ref_setup = 1023; ready = 1'b1;
        step; step;
        chk("c6_settle_iref", 32'(i_ref), 511);
        #2 rst = 1'b0;
        #1;
        chk("c6_rst_iref", 32'(i_ref), 0);
        chk("c6_rst_conv", 32'(converged), 0);
        chk("c6_rst_done", 32'(done), 0);
        step;
        rst = 1'b1;
        run("c6", 110, 1023, 0, 0);

        // Zero-width interval.
        do_reset;
        run("z5", 5, 0, 0, 0);
        chk("z5_iref", 32'(i_ref), 0);
        do_reset;
        run("z0", 0, 0, 0, 0);

        for (int n = 0; n < 24; n++) begin
            gain = int'($urandom_range(1, 8));
            d    = int'($urandom_range(0, (1 << W) - 1));
            s    = int'($urandom_range(0, (1 << W) - 1));
            do_reset;
            run($sformatf("r%0d", n), d, s, (n % 3 == 0) ? 3 : 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
